mcycle: RTL and testbench
=========================

Name: mcycle

Overview:
- Iterative multi-cycle multiply/divide unit for the ALU pipeline, similar to an ARM-style MCycle.
- Performs signed or unsigned WIDTH x WIDTH multiplication, producing a 2*WIDTH-bit product.
- Performs signed or unsigned WIDTH / WIDTH division, producing quotient and remainder.
- Start/Busy handshake; Busy stalls the surrounding pipeline while an operation runs.

Parameters:
- WIDTH, default 4: operand and result width in bits; must be 2 or more.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  request an operation; sampled while idle.
- MCycleOp  input  2  operation: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- Operand1  input  WIDTH  multiplicand / dividend.
- Operand2  input  WIDTH  multiplier / divisor.
- Result1  output  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient.
- Result2  output  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder.
- Busy  output  1  operation in progress; results are not valid while high.

Behaviour:
- Reset (RESET=0, asynchronous): state goes to IDLE; Result1, Result2, counter and all internal registers clear to 0. Busy is 0 while RESET=0.
- Reset mid-operation aborts the operation. Results stay 0 until a new operation completes.
- States: IDLE and COMPUTING.
- IDLE: Busy = Start (combinational, so the pipeline stalls in the same cycle).
- IDLE, rising edge with Start=1:
  - latch MCycleOp;
  - latch the operands, taking their magnitudes when the op is signed;
  - record the result signs;
  - clear the iteration counter;
  - go to COMPUTING.
- COMPUTING: Busy=1. One iteration per rising edge, for WIDTH iterations.
  - On the edge that performs iteration WIDTH: write Result1/Result2, then return to IDLE.
  - Busy falls after that edge unless Start is still 1.
- Latency: Busy stays high for WIDTH+1 clock cycles, counted from the cycle Start is first seen.
- Back-to-back operation: if Start stays 1, the next operation is captured in the cycle after completion, using the operands present then.
- Operand, MCycleOp or Start changes during COMPUTING are ignored; an operation always runs to completion once started.
- Result1/Result2 hold their last values until the next completion, including while Busy is high.
- Multiply:
  - shift-add on magnitudes, 2*WIDTH-bit product;
  - signed op negates the product when the operand signs differ;
  - the result is exact; for WIDTH=4, -8 x -8 = 0100_0000.
- Divide:
  - restoring shift-subtract on magnitudes;
  - signed op truncates toward zero;
  - quotient is negative when the signs differ;
  - remainder takes the sign of the dividend, so dividend = quotient*divisor + remainder.
- Divide by zero: quotient = all ones, remainder = Operand1 as given (no trap).
- Signed overflow, most-negative / -1: quotient wraps to the most-negative value, remainder 0.
- Zero dividend: quotient 0, remainder 0.
- Dividend magnitude smaller than divisor magnitude: quotient 0, remainder = dividend.

Decomposition:
- Shared package mcycle_pkg holds:
  - op encodings MUL_S=2'b00, MUL_U=2'b01, DIV_S=2'b10, DIV_U=2'b11;
  - state enum {IDLE, COMPUTING}.
- No sub-module: the datapath and FSM fit in one module.
- The datapath needs shift registers for multiplicand/multiplier or remainder/quotient, one WIDTH+1-bit adder/subtractor, and a counter of clog2(WIDTH)+1 bits.

Test Plan (WIDTH=4):
- Signed multiply, op 00:
  - 1111 x 1111 -> Result2:Result1 = 0000_0001;
  - 1001 x 1001 -> 0011_0001;
  - 1101 x 0010 -> 1111_1010;
  - 1000 x 0111 -> 1100_1000;
  - 0111 x 1010 -> 1101_0110;
  - 0001 x 1000 -> 1111_1000.
  - In every case Busy is high for exactly 5 cycles.
- Unsigned multiply, op 01: 1111 x 1111 -> 1110_0001. Signed op 00 on the same operands -> 0000_0001.
- Signed divide, op 10, quotient R remainder:
  - 1100 / 0011 -> 1111 R 1111;
  - 1010 / 1100 -> 0001 R 1110;
  - 0011 / 1110 -> 1111 R 0001;
  - 0000 / 1110 -> 0000 R 0000;
  - 1100 / 1100 -> 0001 R 0000.
- Unsigned divide, op 11:
  - 1000 / 0100 -> 0010 R 0000;
  - 0000 / 0101 -> 0000 R 0000;
  - 0100 / 1000 -> 0000 R 0100;
  - 0110 / 0000 -> 1111 R 0110.
- Back-to-back: hold Start=1, change the operands while Busy=1 -> the current result is unaffected. The next operation starts the cycle after Busy falls and uses the new operands.
- Reset: assert RESET=0 mid-COMPUTING -> Busy=0 immediately, results 0000. Release with Start=1 -> a fresh operation completes correctly.

Source files
------------

// File: rtl/mcycle_pkg.sv
// rtl/mcycle_pkg.sv - shared op encodings and state type for the mcycle multiply/divide unit
package mcycle_pkg;

    localparam logic [1:0] MUL_S = 2'b00;
    localparam logic [1:0] MUL_U = 2'b01;
    localparam logic [1:0] DIV_S = 2'b10;
    localparam logic [1:0] DIV_U = 2'b11;

    typedef enum logic {
        IDLE,
        COMPUTING
    } state_t;

endpackage

// File: rtl/mcycle.sv
// rtl/mcycle.sv - iterative shift-add multiplier / restoring divider with Start/Busy handshake
module mcycle
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [CW-1:0]   count;
    logic            op_div;
    logic [WIDTH-1:0] hi;       // mul: product high half / div: partial remainder
    logic [WIDTH-1:0] lo;       // mul: product low half + multiplier / div: dividend -> quotient
    logic [WIDTH-1:0] opb;      // mul: multiplicand magnitude / div: divisor magnitude
    logic [WIDTH-1:0] raw1;
    logic            neg_a;
    logic            neg_r;
    logic            div_zero;

    logic             is_signed;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    always_comb begin
        is_signed = ~MCycleOp[0];
        s1        = is_signed & Operand1[WIDTH-1];
        s2        = is_signed & Operand2[WIDTH-1];
        mag1      = s1 ? -Operand1 : Operand1;
        mag2      = s2 ? -Operand2 : Operand2;
    end

    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic [WIDTH+1:0]   add_y;
    logic               ge;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res1_n;
    logic [WIDTH-1:0]   res2_n;

    // Single shared adder: adds the multiplicand for mul, trial-subtracts the divisor for div.
    always_comb begin
        add_a = op_div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
        add_b = (op_div || lo[0]) ? {1'b0, opb} : '0;
        add_y = op_div ? ({1'b0, add_a} - {1'b0, add_b})
                       : ({1'b0, add_a} + {1'b0, add_b});
        ge    = ~add_y[WIDTH+1];
        if (op_div) begin
            hi_n = ge ? add_y[WIDTH-1:0] : add_a[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end else begin
            hi_n = add_y[WIDTH:1];
            lo_n = {add_y[0], lo[WIDTH-1:1]};
        end
        prod = {hi_n, lo_n};
        if (neg_a) begin
            prod = -prod;
        end
        res1_n = prod[WIDTH-1:0];
        res2_n = prod[2*WIDTH-1:WIDTH];
        if (op_div) begin
            res1_n = neg_a ? -lo_n : lo_n;
            res2_n = neg_r ? -hi_n : hi_n;
            if (div_zero) begin
                res1_n = '1;
                res2_n = raw1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            count    <= '0;
            op_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            raw1     <= '0;
            neg_a    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            Result1  <= '0;
            Result2  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_div   <= MCycleOp[1];
                        count    <= '0;
                        hi       <= '0;
                        neg_a    <= s1 ^ s2;
                        neg_r    <= s1;
                        div_zero <= (Operand2 == '0);
                        raw1     <= Operand1;
                        if (MCycleOp[1]) begin
                            lo  <= mag1;
                            opb <= mag2;
                        end else begin
                            lo  <= mag2;
                            opb <= mag1;
                        end
                        state <= COMPUTING;
                    end
                end
                COMPUTING: begin
                    hi    <= hi_n;
                    lo    <= lo_n;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        Result1 <= res1_n;
                        Result2 <= res2_n;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy follows Start combinationally in IDLE so the pipeline stalls in the request cycle.
    assign Busy = RESET & ((state == COMPUTING) | Start);

endmodule

// File: tb/tb_mcycle.sv
// tb/tb_mcycle.sv - scoreboard testbench for mcycle at WIDTH=4
module tb_mcycle;
    import mcycle_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [W-1:0] res1;
    logic [W-1:0] res2;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] last_res = '0;

    mcycle #(.WIDTH(W)) dut (
        .CLK     (clk),
        .RESET   (rst_n),
        .Start   (start),
        .MCycleOp(op),
        .Operand1(op1),
        .Operand2(op2),
        .Result1 (res1),
        .Result2 (res2),
        .Busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sa, sb_, ua, ub, p, q, r;
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        p = 0; q = 0; r = 0;
        case (o)
            MUL_S: p = sa * sb_;
            MUL_U: p = ua * ub;
            DIV_S: begin
                if (b == '0) begin q = -1; r = ua; end
                else begin q = sa / sb_; r = sa % sb_; end
                p = (r << W) | (q & ((1 << W) - 1));
            end
            default: begin
                if (b == '0) begin q = -1; r = ua; end
                else begin q = ua / ub; r = ua % ub; end
                p = (r << W) | (q & ((1 << W) - 1));
            end
        endcase
        return p[2*W-1:0];
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int cyc;
        logic [2*W-1:0] want;
        sb.push_back(exp);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; op = o; op1 = a; op2 = b;
        #1;
        cyc = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0; op = ~o; op1 = ~a; op2 = b ^ 4'b0101;
        #1;
        check({tag, "_hold"}, {24'd0, res2, res1}, {24'd0, last_res});
        while (busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        want = sb.pop_front();
        check({tag, "_busy_cycles"}, cyc, 5);
        check(tag, {24'd0, res2, res1}, {24'd0, want});
        last_res = want;
    endtask

    initial begin
        int cyc;
        logic ok;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b1; op = MUL_S; op1 = 4'hF; op2 = 4'hF;
        #13;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_res", {24'd0, res2, res1}, 0);

        run_op("smul_m1_m1", MUL_S, 4'b1111, 4'b1111, 8'h01);
        run_op("smul_m7_m7", MUL_S, 4'b1001, 4'b1001, 8'h31);
        run_op("smul_m3_2",  MUL_S, 4'b1101, 4'b0010, 8'hFA);
        run_op("smul_m8_7",  MUL_S, 4'b1000, 4'b0111, 8'hC8);
        run_op("smul_7_m6",  MUL_S, 4'b0111, 4'b1010, 8'hD6);
        run_op("smul_1_m8",  MUL_S, 4'b0001, 4'b1000, 8'hF8);
        run_op("smul_m8_m8", MUL_S, 4'b1000, 4'b1000, 8'h40);
        run_op("umul_15_15", MUL_U, 4'b1111, 4'b1111, 8'hE1);
        run_op("sdiv_m4_3",  DIV_S, 4'b1100, 4'b0011, 8'hFF);
        run_op("sdiv_m6_m4", DIV_S, 4'b1010, 4'b1100, 8'hE1);
        run_op("sdiv_3_m2",  DIV_S, 4'b0011, 4'b1110, 8'h1F);
        run_op("sdiv_0_m2",  DIV_S, 4'b0000, 4'b1110, 8'h00);
        run_op("sdiv_m4_m4", DIV_S, 4'b1100, 4'b1100, 8'h01);
        run_op("sdiv_ovf",   DIV_S, 4'b1000, 4'b1111, 8'h08);
        run_op("sdiv_by0",   DIV_S, 4'b1101, 4'b0000, 8'hDF);
        run_op("udiv_8_4",   DIV_U, 4'b1000, 4'b0100, 8'h02);
        run_op("udiv_0_5",   DIV_U, 4'b0000, 4'b0101, 8'h00);
        run_op("udiv_4_8",   DIV_U, 4'b0100, 4'b1000, 8'h40);
        run_op("udiv_by0",   DIV_U, 4'b0110, 4'b0000, 8'h6F);

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op("random", ro, ra, rb, model(ro, ra, rb));
        end

        // Back-to-back: Start held high, operands switched while the first op runs.
        sb.push_back(8'hD6);
        sb.push_back(8'h02);
        ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op = MUL_S; op1 = 4'b0111; op2 = 4'b1010;
        #1;
        ok = ok & busy;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                op = DIV_U; op1 = 4'b1000; op2 = 4'b0100;
            end
            #1;
            ok = ok & busy;
        end
        check("b2b_busy_held", {31'd0, ok}, 1);
        check("b2b_first", {24'd0, res2, res1}, {24'd0, sb.pop_front()});
        @(negedge clk);
        start = 1'b0;
        #1;
        cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        check("b2b_second_cycles", cyc, 4);
        check("b2b_second", {24'd0, res2, res1}, {24'd0, sb.pop_front()});

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; op = MUL_U; op1 = 4'b1111; op2 = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_res", {24'd0, res2, res1}, 0);
        last_res = '0;
        run_op("after_reset", MUL_S, 4'b1000, 4'b0111, 8'hC8);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
